// File: rtl/block_serializer.sv
// Parallel-to-byte-stream serializer: captures one MAXELEMENTS-byte block and emits
// it LSB byte first on a valid/ready stream, flagging the final byte.
module block_serializer #(
    parameter int MAXELEMENTS = 44,
    parameter int COUNTBITS   = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [MAXELEMENTS*8-1:0] block_in,
    output logic                     byte_valid,
    input  logic                     byte_ready,
    output logic [7:0]               byte_data,
    output logic                     byte_last
);

    localparam int W = MAXELEMENTS * 8;
    localparam logic [COUNTBITS-1:0] LAST_IDX = COUNTBITS'(MAXELEMENTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [COUNTBITS-1:0] count_q, count_d;
    logic [W-1:0]         data_q, data_d;
    logic [W-1:0]         data_shift;
    logic                 beat;
    logic                 load_fire;

    // Byte-lane shift toward lane 0; the top lane is refilled with zero.
    generate
        for (genvar gi = 0; gi < MAXELEMENTS; gi++) begin : g_lane
            if (gi == MAXELEMENTS - 1) begin : g_top
                assign data_shift[8*gi +: 8] = 8'h00;
            end else begin : g_mid
                assign data_shift[8*gi +: 8] = data_q[8*(gi+1) +: 8];
            end
        end
    endgenerate

    // Outputs come straight from registers so reset drops them asynchronously.
    assign byte_valid = (state_q == SEND);
    assign byte_last  = byte_valid & (count_q == LAST_IDX);
    assign byte_data  = data_q[7:0];
    assign beat       = byte_valid & byte_ready;
    assign load_ready = (state_q == IDLE) | (beat & byte_last);
    assign load_fire  = load_valid & load_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (load_fire) begin
                    state_d = SEND;
                    count_d = '0;
                    data_d  = block_in;
                end
            end
            SEND: begin
                if (load_fire) begin
                    // Last beat overlapped with a new load: no bubble between blocks.
                    state_d = SEND;
                    count_d = '0;
                    data_d  = block_in;
                end else if (beat) begin
                    data_d = data_shift;
                    if (byte_last) begin
                        state_d = IDLE;
                        count_d = '0;
                    end else begin
                        count_d = count_q + COUNTBITS'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

endmodule
